// File: rtl/if_stage_if.sv
// Fetch-side bundle: ID handshake (stall/redirect), instruction-memory request/response
// and the IF_ID pipeline register. if_stage uses the master view.
interface if_stage_if #(
  parameter int SIZE = 32
);
  logic              stall;
  logic              redirect_valid;
  logic [SIZE-1:0]   redirect_pc;
  logic              imem_req;
  logic [SIZE-1:0]   imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [SIZE-1:0]   imem_rdata;
  logic [2*SIZE-1:0] IF_ID;
  logic              IF_ID_valid;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, IF_ID, IF_ID_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, IF_ID, IF_ID_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, prefetch FIFO, registered IF_ID.
// Optional IF_PERF_EN adds fetch_count / bubble_count performance counters.
module if_stage #(
  parameter int              SIZE       = 32,
  parameter logic [SIZE-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IF_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  if_stage_if.master  bus
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [SIZE-1:0] ALIGN_MASK = ~SIZE'(3);
  localparam logic [SIZE-1:0] PC_STEP    = SIZE'(4);

  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]        r_state;
  logic [SIZE-1:0]   r_pc;
  logic [SIZE-1:0]   r_req_pc;
  logic              r_outstanding;
  logic [2*SIZE-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [2*SIZE-1:0] r_if_id;
  logic              r_if_id_valid;

  logic [SIZE-1:0]   w_redir_pc;
  logic              w_credit;
  logic              w_req;
  logic              w_fire;
  logic              w_push;
  logic              w_load;
  logic              w_pop;

  // Credit counts the in-flight request so a returning word always has a FIFO slot.
  assign w_redir_pc = bus.redirect_pc & ALIGN_MASK;
  assign w_credit   = (r_count + CW'(r_outstanding)) < DEPTH_C;
  assign w_req      = (r_state == ST_REQ) && w_credit && !bus.redirect_valid;
  assign w_fire     = w_req && bus.imem_ready;
  assign w_push     = (r_state == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign w_load     = !bus.redirect_valid && (!r_if_id_valid || !bus.stall);
  assign w_pop      = w_load && (r_count != '0);

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.IF_ID       = r_if_id;
  assign bus.IF_ID_valid = r_if_id_valid;

  // Fetch FSM and PC; a redirect retargets the PC but never cancels a request already accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redir_pc;
          end else if (w_fire) begin
            r_req_pc      <= r_pc;
            r_pc          <= r_pc + PC_STEP;
            r_outstanding <= 1'b1;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DISCARD: begin
          if (bus.imem_rvalid) begin
            r_outstanding <= 1'b0;
            r_state       <= ST_REQ;
          end else if (bus.redirect_valid) begin
            r_state <= ST_DISCARD;
          end
          if (bus.redirect_valid) begin
            r_pc <= w_redir_pc;
          end
        end
        default: begin
          r_state       <= ST_REQ;
          r_outstanding <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {r_req_pc, bus.imem_rdata};
    end
  end

  // FIFO bookkeeping and the IF_ID register; redirect flushes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_if_id       <= '0;
      r_if_id_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_if_id_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_load) begin
        if (w_pop) begin
          r_if_id       <= r_fifo[r_rd_ptr];
          r_if_id_valid <= 1'b1;
        end else begin
          r_if_id_valid <= 1'b0;
        end
      end
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  // Accepted requests and cycles where ID was ready but had nothing to take.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_fire) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (!r_if_id_valid && !bus.stall) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, hand-written redirect/reset sequences, then
// random stall/redirect/memory-latency traffic against a sequential-stream reference model.
module tb_if_stage;
  localparam int          SIZE     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if #(.SIZE(SIZE)) bus ();
`ifdef IF_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  if_stage #(.SIZE(SIZE), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef IF_PERF_EN
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count),
`endif
    .bus          (bus)
  );

  typedef struct {
    bit          stall;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    bit          exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [14];

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  // memory model
  bit          mem_hold   = 1'b0;
  bit          rand_ready = 1'b0;
  int          mem_lat    = 0;
  bit          pend       = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait;

  // reference model of the fetch / output streams
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  bit          prev_valid = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_redir = 1'b0;
  logic [63:0] prev_ifid;
  bit          last_fire = 1'b0;
  logic [31:0] last_fire_addr;
`ifdef IF_PERF_EN
  logic [31:0] m_fetch  = 32'd0;
  logic [31:0] m_bubble = 32'd0;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: scoreboard this cycle, advance one edge, update the memory model.
  task automatic tick();
    bit          fire_s;
    bit          rst_s;
    bit          rv_s;
    logic [31:0] addr_s;
    rst_s  = rst;
    rv_s   = bus.imem_rvalid;
    addr_s = bus.imem_addr;
    fire_s = bus.imem_req && bus.imem_ready && !rst;
    if (!rst) begin
      if (pend) check("one_outstanding", bus.imem_req, 1'b0);
      if (bus.redirect_valid) check("req_masked_by_redirect", bus.imem_req, 1'b0);
      if (fire_s) begin
        check("fetch_addr", addr_s, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (prev_redir) check("valid_after_redirect", bus.IF_ID_valid, 1'b0);
      else if (prev_valid && prev_stall) check("stall_hold", {bus.IF_ID_valid, bus.IF_ID}, {1'b1, prev_ifid});
      if (bus.IF_ID_valid && !bus.stall) begin
        check("if_id_stream", bus.IF_ID, {exp_pc, mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        n_out++;
      end
      if (bus.redirect_valid) begin
        exp_pc    = {bus.redirect_pc[31:2], 2'b00};
        exp_fetch = {bus.redirect_pc[31:2], 2'b00};
      end
    end
`ifdef IF_PERF_EN
    if (rst_s) begin
      m_fetch  = 32'd0;
      m_bubble = 32'd0;
    end else begin
      if (fire_s) m_fetch = m_fetch + 32'd1;
      if (!bus.IF_ID_valid && !bus.stall) m_bubble = m_bubble + 32'd1;
    end
`endif
    prev_valid     = bus.IF_ID_valid && !rst_s;
    prev_stall     = bus.stall;
    prev_redir     = bus.redirect_valid && !rst_s;
    prev_ifid      = bus.IF_ID;
    last_fire      = fire_s;
    last_fire_addr = addr_s;

    @(posedge clk);
    #1;
    if (rst_s) begin
      pend      = 1'b0;
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
    end else begin
      if (rv_s) pend = 1'b0;
      if (fire_s) begin
        pend      = 1'b1;
        pend_addr = addr_s;
        pend_wait = mem_lat;
      end
    end
    if (!mem_hold) begin
      bus.imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_addr);
        end else begin
          pend_wait--;
        end
      end
      bus.imem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_fire(input string name, output logic [31:0] addr);
    int k = 0;
    do begin
      step();
      k++;
    end while (!last_fire && k < 40);
    if (!last_fire) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no accepted request within 40 cycles", name);
    end
    addr = last_fire_addr;
  endtask

  task automatic wait_valid(input string name, input logic [63:0] exp);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.IF_ID_valid) begin
        found = 1'b1;
        check(name, bus.IF_ID, exp);
      end
      tick();
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no valid IF_ID within 40 cycles", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          out_before;

    // zero-wait memory; stall held cycles 7..10 while IF_ID = {8,0x108}
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 32'h000, 1'b1, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 32'h00, 32'h000, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b0, 32'h00, 32'h000, 1'b1, 32'h04};
    tbl[3]  = '{1'b0, 1'b1, 32'h00, 32'h100, 1'b0, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, 32'h100, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 32'h04, 32'h104, 1'b0, 32'h00};
    tbl[6]  = '{1'b0, 1'b0, 32'h04, 32'h104, 1'b1, 32'h0C};
    tbl[7]  = '{1'b1, 1'b1, 32'h08, 32'h108, 1'b0, 32'h00};
    tbl[8]  = '{1'b1, 1'b1, 32'h08, 32'h108, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 1'b1, 32'h08, 32'h108, 1'b0, 32'h00};
    tbl[10] = '{1'b1, 1'b1, 32'h08, 32'h108, 1'b0, 32'h00};
    tbl[11] = '{1'b0, 1'b1, 32'h08, 32'h108, 1'b0, 32'h00};
    tbl[12] = '{1'b0, 1'b1, 32'h0C, 32'h10C, 1'b1, 32'h14};
    tbl[13] = '{1'b0, 1'b1, 32'h10, 32'h110, 1'b0, 32'h00};

    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_ready     = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    mem_lat            = 0;
    do_reset(2);

    for (int i = 0; i < 14; i++) begin
      bus.stall = tbl[i].stall;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), bus.IF_ID_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_if_id", i), bus.IF_ID, {tbl[i].exp_pc, tbl[i].exp_ins});
      check($sformatf("tbl%0d_req", i), bus.imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].exp_addr);
      tick();
    end
    bus.stall = 1'b0;

    // redirect while waiting; the in-flight response arrives two cycles later
    mem_lat = 2;
    wait_fire("redir_wait_fire", a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    step();
    bus.redirect_valid = 1'b0;
    wait_fire("redir_next_fire", a);
    check("redir_next_addr", a, 32'h40);
    wait_valid("redir_first_out", {32'h40, 32'h140});

    // redirect coincident with rvalid
    mem_lat = 0;
    wait_fire("same_cycle_fire", a);
    check("same_cycle_rvalid", bus.imem_rvalid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("same_cycle_valid", bus.IF_ID_valid, 1'b0);
    check("same_cycle_req", bus.imem_req, 1'b1);
    check("same_cycle_addr", bus.imem_addr, 32'h200);
    tick();

    // PC wrap
    mem_lat = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    wait_fire("wrap_fire0", a);
    check("wrap_addr0", a, 32'hFFFF_FFFC);
    wait_fire("wrap_fire1", a);
    check("wrap_addr1", a, 32'h0000_0000);

    // reset while waiting; stale rvalid in the first cycle after reset
    mem_lat = 3;
    wait_fire("rst_wait_fire", a);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_hold        = 1'b1;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_ready  = 1'b1;
    mem_hold        = 1'b0;
`ifdef IF_PERF_EN
    check("perf_fetch_after_reset", fetch_count, 32'd0);
`endif
    wait_valid("reset_first_out", {RESET_PC, mem_word(RESET_PC)});

    // random traffic
    rand_ready = 1'b1;
    out_before = n_out;
    for (int c = 0; c < 3000; c++) begin
      mem_lat   = $urandom_range(0, 3);
      bus.stall = ($urandom_range(0, 9) < 3);
      bus.redirect_valid = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) bus.redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else bus.redirect_pc = $urandom;
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    check("random_progress", (n_out - out_before) > 100, 1'b1);
`ifdef IF_PERF_EN
    check("perf_fetch_count", fetch_count, m_fetch);
    check("perf_bubble_count", bubble_count, m_bubble);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the ID stage. It holds the PC and issues single-outstanding requests to an instruction memory with variable latency. Returned words are buffered in a small FIFO and presented on the registered IF_ID pipeline register as {PC, instruction}. It honours stall from ID and redirect (branch/jump) from downstream stages.

Parameters:
SIZE, 32, datapath/instruction/address width in bits
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 2, prefetch FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  ID cannot accept; hold IF_ID
redirect_valid  input  1  redirect fetch to redirect_pc
redirect_pc  input  SIZE  new fetch address; bits [1:0] ignored (forced 0)
imem_req  output  1  request valid (combinational from state/credit)
imem_addr  output  SIZE  request address (= pc)
imem_ready  input  1  memory accepts request this cycle when imem_req=1
imem_rvalid  input  1  response data valid
imem_rdata  input  SIZE  instruction word
IF_ID  output  2*SIZE  registered; [2*SIZE-1:SIZE] = PC of instruction, [SIZE-1:0] = instruction
IF_ID_valid  output  1  IF_ID holds a live instruction

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, state<=REQ, FIFO empty, outstanding cleared, IF_ID<=0, IF_ID_valid<=0. Reset mid-transaction: any later imem_rvalid for the pre-reset request is dropped (outstanding flag cleared, so state REQ ignores rvalid).
- credit = (fifo_count + outstanding) < FIFO_DEPTH; outstanding is 0 or 1.
- FSM states: REQ, WAIT, DISCARD.
  - REQ: imem_req = credit && !redirect_valid; imem_addr = pc. On imem_req && imem_ready: req_pc<=pc, pc<=pc+4 (wraps modulo 2^SIZE), outstanding<=1, go WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {req_pc, imem_rdata}, outstanding<=0, go REQ.
  - DISCARD: imem_req=0. On imem_rvalid: drop the data, outstanding<=0, go REQ.
- Redirect (highest priority, overrides stall):
  - pc<=redirect_pc & ~3, FIFO flushed, IF_ID_valid<=0.
  - REQ: no request issued this cycle.
  - WAIT: without simultaneous rvalid go DISCARD; with simultaneous rvalid drop the data and go REQ.
  - DISCARD: update pc, stay DISCARD.
- Output register (no redirect): if !IF_ID_valid || !stall:
  - FIFO non-empty: IF_ID<=head, pop, IF_ID_valid<=1.
  - FIFO empty: IF_ID_valid<=0, IF_ID holds its value.
  - If stall && IF_ID_valid: IF_ID and IF_ID_valid hold.
- Latency: with zero-wait memory (ready=1, rvalid the cycle after the request), the first IF_ID_valid occurs 3 cycles after reset deasserts.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged. Push is never attempted when full (credit guarantees this).
- imem_rvalid outside WAIT/DISCARD is ignored.

Optional Feature:
IF_PERF_EN: when defined, adds outputs fetch_count (32, increments on each accepted imem request) and bubble_count (32, increments each cycle IF_ID_valid=0 while stall=0). Both counters reset to 0 on rst and wrap. When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory returning addr+0x100 -> IF_ID sequence {0,0x100},{4,0x104},{8,0x108}; IF_ID_valid first high 3 cycles after rst falls.
- Hold stall=1 for 4 cycles with IF_ID={8,0x108} -> IF_ID unchanged; imem_req drops once FIFO holds 2 entries; after release the next outputs are {0xC,...},{0x10,...} in order, with none lost.
- redirect_valid with redirect_pc=0x43 while in WAIT, rvalid 2 cycles later -> that response is dropped; the next request has imem_addr=0x40, and the next valid IF_ID is {0x40,...}.
- redirect_valid in the same cycle as imem_rvalid -> data dropped, FSM goes REQ, FIFO empty, IF_ID_valid=0 the next cycle.
- PC wrap: redirect to 0xFFFFFFFC -> next fetch addresses are 0xFFFFFFFC, then 0x00000000.
- rst asserted while in WAIT, stale rvalid arrives 1 cycle after rst drops -> ignored; first IF_ID is {RESET_PC,...}. With IF_PERF_EN, fetch_count=0 after reset.
